// File: rtl/generic_2clk_fifo_rd_stream_adapter_if.sv
// Stream interface for the read-side drain stage of the 2-clock FIFO.
// Carries the valid/ready word stream toward the rd_clk-domain consumer.
//   out_valid : word available (driven by the adapter)
//   out_ready : consumer accepts the word when out_valid && out_ready
//   out_data  : stream word, oldest first (driven by the adapter)
// master modport is the adapter side, slave modport is the consumer side.
interface generic_2clk_fifo_rd_stream_adapter_if #(
  parameter int unsigned DAT_WIDTH = 17
);
  logic                 out_valid;
  logic                 out_ready;
  logic [DAT_WIDTH-1:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/generic_2clk_fifo_rd_stream_adapter.sv
// Read-side drain stage for the 2-clock FIFO + 2-port RF pair.
// Issues rd_op toward the FIFO, captures rd_data RD_LATENCY cycles later into a small
// circular prefetch store and presents the words on a valid/ready stream.
// A credit check on store occupancy plus in-flight reads keeps the store from overflowing
// while sustaining one word per clock when BUF_DEPTH >= RD_LATENCY+1.
// Ports:
//   rd_clk    : read-domain clock
//   rd_reset  : asynchronous reset, active-high
//   rd_empty  : FIFO empty, already reflects rd_op issued in earlier cycles
//   rd_op     : FIFO read strobe (also RF read enable)
//   rd_data   : RF read data, valid RD_LATENCY cycles after rd_op
//   flush     : synchronous drop of buffered and in-flight words
//   out_if    : stream master (out_valid / out_ready / out_data)
//   buf_level : words currently held in the prefetch store
module generic_2clk_fifo_rd_stream_adapter #(
  parameter int unsigned DAT_WIDTH  = 17,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic                               rd_clk,
  input  logic                               rd_reset,
  input  logic                               rd_empty,
  output logic                               rd_op,
  input  logic [DAT_WIDTH-1:0]               rd_data,
  input  logic                               flush,
  generic_2clk_fifo_rd_stream_adapter_if.master out_if,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     buf_level
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  if (BUF_DEPTH < 1 || RD_LATENCY < 1) begin : g_bad_param
    $error("generic_2clk_fifo_rd_stream_adapter: BUF_DEPTH and RD_LATENCY must be >= 1");
  end

  logic [RD_LATENCY-1:0] infl_q, infl_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      level_q, level_d;
  logic [DAT_WIDTH-1:0]  mem_q [BUF_DEPTH];

  logic        pop;
  logic        capture;
  logic        wr_en;
  logic        pop_en;
  logic        credit_ok;
  int unsigned infl_cnt;

  // Pointers wrap at BUF_DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_if.out_valid = (level_q != '0);
  assign out_if.out_data  = mem_q[rd_ptr_q];
  assign buf_level        = level_q;

  assign pop     = out_if.out_valid && out_if.out_ready;
  assign capture = infl_q[RD_LATENCY-1];
  // A flush discards both the word arriving this cycle and any same-cycle pop.
  assign wr_en   = capture && !flush;
  assign pop_en  = pop && !flush;

  always_comb begin
    infl_cnt = 0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      if (infl_q[i]) infl_cnt++;
    end
  end

  // Credit: stored + in-flight words, less the word leaving this cycle, must leave room.
  assign credit_ok = (32'(level_q) + infl_cnt) < (BUF_DEPTH + 32'(pop));
  // Gated by rd_reset so the strobe drops the moment reset asserts.
  assign rd_op     = !rd_reset && !rd_empty && !flush && credit_ok;

  always_comb begin
    infl_d = '0;
    if (!flush) begin
      infl_d[0] = rd_op;
      for (int i = 1; i < RD_LATENCY; i++) begin
        infl_d[i] = infl_q[i-1];
      end
    end
  end

  always_comb begin
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_en) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (wr_en && !pop_en) begin
        level_d = level_q + CNT_W'(1);
      end else if (!wr_en && pop_en) begin
        level_d = level_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge rd_clk or posedge rd_reset) begin
    if (rd_reset) begin
      infl_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      infl_q   <= infl_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Store is cleared on reset so out_data reads zero until the first capture.
  always_ff @(posedge rd_clk or posedge rd_reset) begin
    if (rd_reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= rd_data;
    end
  end

  a_no_overflow : assert property (@(posedge rd_clk) disable iff (rd_reset)
    capture |-> (level_q != CNT_W'(BUF_DEPTH)));

  a_no_read_empty : assert property (@(posedge rd_clk) disable iff (rd_reset)
    rd_op |-> !rd_empty);

endmodule
